bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter. It is the common building block for the seconds, minutes and hours stages of the top-down clock (MODULO 60/60/24).
- Chains through single-cycle carry/borrow pulses.
- Adds decrement, so the user can adjust time in both directions.
- Adds synchronous parallel load with validity checking, so the time can be preset.

---
 rtl/clock_pkg.sv | 19 +
 rtl/bcd_digit_step.sv | 33 +++
 rtl/bcd_mod_counter.sv | 138 +++++++++++++
 tb/tb_bcd_mod_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day counter stages.
// Elaboration-time helpers split a binary constant into BCD digits.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_MODULO  = 60;
  localparam int MIN_MODULO  = 60;
  localparam int HOUR_MODULO = 24;

  function automatic bcd_digit_t to_bcd_msd(input int v);
    return bcd_digit_t'((v / 10) % 10);
  endfunction

  function automatic bcd_digit_t to_bcd_lsd(input int v);
    return bcd_digit_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit stepped up or down, wrapping at a digit limit.
// Purely combinational; the caller owns the register.
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       up_i,
  input  bcd_digit_t limit_i,
  output bcd_digit_t next_o,
  output logic       wrap_o
);

  always_comb begin
    next_o = digit_i;
    wrap_o = 1'b0;
    if (up_i) begin
      if (digit_i >= limit_i) begin
        next_o = '0;
        wrap_o = 1'b1;
      end else begin
        next_o = digit_i + 4'd1;
      end
    end else begin
      if (digit_i == '0) begin
        next_o = limit_i;
        wrap_o = 1'b1;
      end else begin
        next_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down modulo counter with checked parallel load.
// Carry/borrow are registered pulses so stages chain inc <- carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULO    = 60,
  parameter int RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_msd,
  input  logic [3:0] load_lsd,
  output logic [3:0] bcd_lsd,
  output logic [3:0] bcd_msd,
  output logic       carry,
  output logic       borrow,
  output logic       load_err,
  output logic       at_max
);

  if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
    $error("bcd_mod_counter: MODULO must be 2..100");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset
    $error("bcd_mod_counter: RESET_VAL must be 0..MODULO-1");
  end

  localparam bcd_digit_t MAX_MSD = to_bcd_msd(MODULO - 1);
  localparam bcd_digit_t MAX_LSD = to_bcd_lsd(MODULO - 1);
  localparam bcd_digit_t RST_MSD = to_bcd_msd(RESET_VAL);
  localparam bcd_digit_t RST_LSD = to_bcd_lsd(RESET_VAL);
  localparam bcd_digit_t NINE    = 4'd9;

  bcd_digit_t msd_q, msd_d;
  bcd_digit_t lsd_q, lsd_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       err_q, err_d;

  logic       do_load, do_inc, do_dec;
  logic       max_hit, zero_hit, load_ok;
  bcd_digit_t lsd_step, msd_step;
  logic       lsd_wrap, msd_wrap_unused;

  // Operations are made one-hot so the decoder below can be unique.
  assign do_load = load;
  assign do_inc  = !load && inc && !dec;
  assign do_dec  = !load && dec && !inc;

  assign max_hit  = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
  assign zero_hit = (msd_q == '0) && (lsd_q == '0);

  assign load_ok = (load_msd <= NINE) && (load_lsd <= NINE) &&
                   ((load_msd < MAX_MSD) ||
                    ((load_msd == MAX_MSD) && (load_lsd <= MAX_LSD)));

  bcd_digit_step u_lsd_step (
    .digit_i (lsd_q),
    .up_i    (do_inc),
    .limit_i (NINE),
    .next_o  (lsd_step),
    .wrap_o  (lsd_wrap)
  );

  bcd_digit_step u_msd_step (
    .digit_i (msd_q),
    .up_i    (do_inc),
    .limit_i (NINE),
    .next_o  (msd_step),
    .wrap_o  (msd_wrap_unused)
  );

  always_comb begin
    msd_d    = msd_q;
    lsd_d    = lsd_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      do_load: begin
        if (load_ok) begin
          msd_d = load_msd;
          lsd_d = load_lsd;
        end else begin
          err_d = 1'b1;
        end
      end
      do_inc: begin
        if (max_hit) begin
          msd_d   = '0;
          lsd_d   = '0;
          carry_d = 1'b1;
        end else begin
          lsd_d = lsd_step;
          if (lsd_wrap) msd_d = msd_step;
        end
      end
      do_dec: begin
        if (zero_hit) begin
          msd_d    = MAX_MSD;
          lsd_d    = MAX_LSD;
          borrow_d = 1'b1;
        end else begin
          lsd_d = lsd_step;
          if (lsd_wrap) msd_d = msd_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msd_q    <= RST_MSD;
      lsd_q    <= RST_LSD;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      msd_q    <= msd_d;
      lsd_q    <= lsd_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign bcd_msd  = msd_q;
  assign bcd_lsd  = lsd_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = err_q;
  assign at_max   = max_hit;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Random and directed checks of bcd_mod_counter against an integer model,
// plus a 60/60/24 chain rippling carries from 23:59:59.
module tb_bcd_mod_counter;

  localparam int N = 4;

  function automatic int mod_of(input int g);
    case (g)
      0: return 60;
      1: return 24;
      2: return 60;
      default: return 7;
    endcase
  endfunction

  function automatic int rv_of(input int g);
    case (g)
      2: return 59;
      3: return 3;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lm = 4'd0;
  logic [3:0] ll = 4'd0;

  logic [3:0] msd [N];
  logic [3:0] lsd [N];
  logic       cry [N];
  logic       brw [N];
  logic       err [N];
  logic       amx [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_mod_counter #(
      .MODULO    (mod_of(g)),
      .RESET_VAL (rv_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .dec      (dec),
      .load     (load),
      .load_msd (lm),
      .load_lsd (ll),
      .bcd_lsd  (lsd[g]),
      .bcd_msd  (msd[g]),
      .carry    (cry[g]),
      .borrow   (brw[g]),
      .load_err (err[g]),
      .at_max   (amx[g])
    );
  end

  logic       c_rst = 1'b1;
  logic       tick = 1'b0;
  logic       c_load = 1'b0;
  logic [3:0] c_lm [3] = '{4'd0, 4'd0, 4'd0};
  logic [3:0] c_ll [3] = '{4'd0, 4'd0, 4'd0};
  logic [3:0] c_msd [3];
  logic [3:0] c_lsd [3];
  logic       c_cry [3];
  logic       c_brw [3];
  logic       c_err [3];
  logic       c_amx [3];
  logic       c_inc [3];

  assign c_inc[0] = tick;
  assign c_inc[1] = c_cry[0];
  assign c_inc[2] = c_cry[1];

  for (genvar s = 0; s < 3; s++) begin : g_chain
    bcd_mod_counter #(
      .MODULO    (s == 2 ? 24 : 60),
      .RESET_VAL (0)
    ) u_stage (
      .clk      (clk),
      .rst      (c_rst),
      .inc      (c_inc[s]),
      .dec      (1'b0),
      .load     (c_load),
      .load_msd (c_lm[s]),
      .load_lsd (c_ll[s]),
      .bcd_lsd  (c_lsd[s]),
      .bcd_msd  (c_msd[s]),
      .carry    (c_cry[s]),
      .borrow   (c_brw[s]),
      .load_err (c_err[s]),
      .at_max   (c_amx[s])
    );
  end

  int checks = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Integer reference: value kept in binary, wrap via plain arithmetic.
  function automatic void mstep(input int m, input int rv, input bit r,
                                input bit ld, input int dm, input int dl,
                                input bit up, input bit dn, inout int v,
                                output bit c, output bit b, output bit e);
    c = 0;
    b = 0;
    e = 0;
    if (r) v = rv;
    else if (ld) begin
      if (dm <= 9 && dl <= 9 && dm * 10 + dl < m) v = dm * 10 + dl;
      else e = 1;
    end else if (up && dn) begin
    end else if (up) begin
      if (v == m - 1) begin
        v = 0;
        c = 1;
      end else v = v + 1;
    end else if (dn) begin
      if (v == 0) begin
        v = m - 1;
        b = 1;
      end else v = v - 1;
    end
  endfunction

  int v [N];
  bit mc [N];
  bit mb [N];
  bit me [N];
  int cv [3];
  bit cc [3];
  bit cb [3];
  bit ce [3];
  int hc_seen = 0;

  task automatic cycle();
    bit pc0, pc1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mstep(mod_of(i), rv_of(i), rst, load, int'(lm), int'(ll),
            inc, dec, v[i], mc[i], mb[i], me[i]);
      check($sformatf("u%0d_msd", i), 8'(msd[i]), 8'(v[i] / 10));
      check($sformatf("u%0d_lsd", i), 8'(lsd[i]), 8'(v[i] % 10));
      check($sformatf("u%0d_carry", i), 8'(cry[i]), 8'(mc[i]));
      check($sformatf("u%0d_borrow", i), 8'(brw[i]), 8'(mb[i]));
      check($sformatf("u%0d_lderr", i), 8'(err[i]), 8'(me[i]));
      check($sformatf("u%0d_atmax", i), 8'(amx[i]),
            8'(v[i] == mod_of(i) - 1));
    end
    pc0 = cc[0];
    pc1 = cc[1];
    mstep(60, 0, c_rst, c_load, int'(c_lm[0]), int'(c_ll[0]),
          tick, 0, cv[0], cc[0], cb[0], ce[0]);
    mstep(60, 0, c_rst, c_load, int'(c_lm[1]), int'(c_ll[1]),
          pc0, 0, cv[1], cc[1], cb[1], ce[1]);
    mstep(24, 0, c_rst, c_load, int'(c_lm[2]), int'(c_ll[2]),
          pc1, 0, cv[2], cc[2], cb[2], ce[2]);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("c%0d_bcd", s), {c_msd[s], c_lsd[s]},
            {4'(cv[s] / 10), 4'(cv[s] % 10)});
      check($sformatf("c%0d_carry", s), 8'(c_cry[s]), 8'(cc[s]));
      check($sformatf("c%0d_lderr", s), 8'(c_err[s]), 8'(ce[s]));
    end
    if (c_cry[2] === 1'b1) hc_seen++;
  endtask

  task automatic do_load(input logic [3:0] m, input logic [3:0] l);
    load = 1'b1;
    lm = m;
    ll = l;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) v[i] = 0;
    for (int s = 0; s < 3; s++) cv[s] = 0;
    cycle();
    rst = 1'b0;
    c_rst = 1'b0;

    inc = 1'b1;
    repeat (59) cycle();
    check("p1_at59", {msd[0], lsd[0]}, 8'h59);
    check("p1_atmax", 8'(amx[0]), 8'd1);
    check("p1_nocarry", 8'(cry[0]), 8'd0);
    cycle();
    check("p1_wrap", {msd[0], lsd[0]}, 8'h00);
    check("p1_carry", 8'(cry[0]), 8'd1);
    inc = 1'b0;
    cycle();
    check("p1_carry_once", 8'(cry[0]), 8'd0);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    dec = 1'b1;
    cycle();
    dec = 1'b0;
    check("p2_dec24", {msd[1], lsd[1]}, 8'h23);
    check("p2_borrow", 8'(brw[1]), 8'd1);
    inc = 1'b1;
    cycle();
    check("p2_inc24", {msd[1], lsd[1]}, 8'h00);
    check("p2_carry24", 8'(cry[1]), 8'd1);
    inc = 1'b0;
    do_load(4'd0, 4'd9);
    inc = 1'b1;
    cycle();
    inc = 1'b0;
    check("p2_09to10", {msd[1], lsd[1]}, 8'h10);
    check("p2_nocarry", 8'(cry[1]), 8'd0);

    do_load(4'd4, 4'd7);
    check("p3_ld47", {msd[0], lsd[0]}, 8'h47);
    do_load(4'd6, 4'd0);
    check("p3_ld60_hold", {msd[0], lsd[0]}, 8'h47);
    check("p3_ld60_err", 8'(err[0]), 8'd1);
    do_load(4'd2, 4'hA);
    check("p3_ld2A_err", 8'(err[0]), 8'd1);
    inc = 1'b1;
    do_load(4'd1, 4'd2);
    inc = 1'b0;
    check("p3_ldinc", {msd[0], lsd[0]}, 8'h12);

    do_load(4'd5, 4'd9);
    inc = 1'b1;
    dec = 1'b1;
    cycle();
    inc = 1'b0;
    dec = 1'b0;
    check("p4_hold", {msd[0], lsd[0]}, 8'h59);
    check("p4_pulses", {7'd0, cry[0] | brw[0]}, 8'd0);

    do_load(4'd3, 4'd8);
    rst = 1'b1;
    inc = 1'b1;
    cycle();
    rst = 1'b0;
    inc = 1'b0;
    check("p5_rv59", {msd[2], lsd[2]}, 8'h59);
    check("p5_rv0", {msd[0], lsd[0]}, 8'h00);

    c_rst = 1'b1;
    cycle();
    c_rst = 1'b0;
    c_load = 1'b1;
    c_lm = '{4'd5, 4'd5, 4'd2};
    c_ll = '{4'd9, 4'd9, 4'd3};
    cycle();
    c_load = 1'b0;
    hc_seen = 0;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    repeat (4) cycle();
    check("p6_hours_carry_once", 8'(hc_seen), 8'd1);
    check("p6_hh", {c_msd[2], c_lsd[2]}, 8'h00);
    check("p6_mm", {c_msd[1], c_lsd[1]}, 8'h00);
    check("p6_ss", {c_msd[0], c_lsd[0]}, 8'h00);

    repeat (800) begin
      rst = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 9) == 0);
      lm = 4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 7 : 15));
      ll = 4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 7 : 15));
      inc = $urandom_range(0, 1) == 1;
      dec = $urandom_range(0, 2) == 0;
      c_rst = ($urandom_range(0, 199) == 0);
      c_load = ($urandom_range(0, 49) == 0);
      for (int s = 0; s < 3; s++) begin
        c_lm[s] = 4'($urandom_range(0, 6));
        c_ll[s] = 4'($urandom_range(0, 9));
      end
      tick = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
